collision_detect: RTL and testbench

- Downstream consumer of the per-pixel object values produced in the video peripheral: player 0, player 1, missile 0, missile 1, ball and playfield.
- Latches the 15 object-pair overlaps (TIA-style CXxx) that occur while the beam is inside the visible image.
- Captures beam position of first unmasked collision since last clear.
- Exposes results through a small byte-wide register window, muxed into the peripheral read path.

---
 rtl/collision_detect_pkg.sv | 39 +++
 rtl/collision_pair_matrix.sv | 34 +++
 rtl/collision_detect.sv | 124 ++++++++++++
 tb/tb_collision_detect.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/collision_detect_pkg.sv
// Shared constants for the collision detector: pair bit positions, register
// window addresses and the fixed pair count.
package collision_detect_pkg;

  localparam int NUM_PAIRS = 15;

  // Bit positions inside the hit/latch/mask vectors
  localparam int CX_M0P1 = 0;
  localparam int CX_M0P0 = 1;
  localparam int CX_M1P0 = 2;
  localparam int CX_M1P1 = 3;
  localparam int CX_P0PF = 4;
  localparam int CX_P0BL = 5;
  localparam int CX_P1PF = 6;
  localparam int CX_P1BL = 7;
  localparam int CX_M0PF = 8;
  localparam int CX_M0BL = 9;
  localparam int CX_M1PF = 10;
  localparam int CX_M1BL = 11;
  localparam int CX_BLPF = 12;
  localparam int CX_P0P1 = 13;
  localparam int CX_M0M1 = 14;

  localparam logic [3:0] CX_LO      = 4'h0;
  localparam logic [3:0] CX_HI      = 4'h1;
  localparam logic [3:0] CX_MASK_LO = 4'h2;
  localparam logic [3:0] CX_MASK_HI = 4'h3;
  localparam logic [3:0] CX_FX_LO   = 4'h4;
  localparam logic [3:0] CX_FX_HI   = 4'h5;
  localparam logic [3:0] CX_FY_LO   = 4'h6;
  localparam logic [3:0] CX_FY_HI   = 4'h7;
  localparam logic [3:0] CX_CLEAR   = 4'h8;

  // Upper seven pair bits presented as a byte with bit 7 zero
  function automatic logic [7:0] pair_hi_byte(input logic [NUM_PAIRS-1:0] v);
    return {1'b0, v[14:8]};
  endfunction

endpackage

// File: rtl/collision_pair_matrix.sv
// Combinational AND of the six object pixels into the 15 collision pairs.
// Zero latency; no flow control.
module collision_pair_matrix
  import collision_detect_pkg::*;
(
  input  logic                 p0,
  input  logic                 p1,
  input  logic                 m0,
  input  logic                 m1,
  input  logic                 bl,
  input  logic                 pf,
  output logic [NUM_PAIRS-1:0] hit
);

  always_comb begin
    hit          = '0;
    hit[CX_M0P1] = m0 & p1;
    hit[CX_M0P0] = m0 & p0;
    hit[CX_M1P0] = m1 & p0;
    hit[CX_M1P1] = m1 & p1;
    hit[CX_P0PF] = p0 & pf;
    hit[CX_P0BL] = p0 & bl;
    hit[CX_P1PF] = p1 & pf;
    hit[CX_P1BL] = p1 & bl;
    hit[CX_M0PF] = m0 & pf;
    hit[CX_M0BL] = m0 & bl;
    hit[CX_M1PF] = m1 & pf;
    hit[CX_M1BL] = m1 & bl;
    hit[CX_BLPF] = bl & pf;
    hit[CX_P0P1] = p0 & p1;
    hit[CX_M0M1] = m0 & m1;
  end

endmodule

// File: rtl/collision_detect.sv
// Sticky collision latches with mask and first-hit beam capture behind a byte register window.
// Pixel-to-latch and read-to-data_out are one cycle; no backpressure, every visible pixel is sampled.
module collision_detect
  import collision_detect_pkg::*;
#(
  parameter int POS_WIDTH = 10
) (
  input  logic                 raw_clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 write_enable,
  input  logic [3:0]           address,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  input  logic                 in_image,
  input  logic [POS_WIDTH-1:0] hpos,
  input  logic [POS_WIDTH-1:0] vpos,
  input  logic                 p0,
  input  logic                 p1,
  input  logic                 m0,
  input  logic                 m1,
  input  logic                 bl,
  input  logic                 pf,
  output logic                 collision_any
);

  logic [NUM_PAIRS-1:0] hit;
  logic [NUM_PAIRS-1:0] hit_live;

  logic [NUM_PAIRS-1:0] latch_q, latch_d;
  logic [NUM_PAIRS-1:0] mask_q, mask_d;
  logic [POS_WIDTH-1:0] first_x_q, first_x_d;
  logic [POS_WIDTH-1:0] first_y_q, first_y_d;
  logic                 first_valid_q, first_valid_d;
  logic [7:0]           data_out_q, data_out_d;
  logic [7:0]           rd_dat;
  logic                 wr_clear;

  collision_pair_matrix u_matrix (
    .p0  (p0),
    .p1  (p1),
    .m0  (m0),
    .m1  (m1),
    .bl  (bl),
    .pf  (pf),
    .hit (hit)
  );

  assign wr_clear = write_enable && (address == CX_CLEAR);
  assign hit_live = hit & ~mask_q;

  // A clear on the same edge as a hit wins; that pixel is dropped entirely
  always_comb begin
    latch_d       = latch_q;
    first_x_d     = first_x_q;
    first_y_d     = first_y_q;
    first_valid_d = first_valid_q;
    if (wr_clear) begin
      latch_d       = '0;
      first_valid_d = 1'b0;
    end else if (in_image) begin
      latch_d = latch_q | hit;
      if (!first_valid_q && (|hit_live)) begin
        first_x_d     = hpos;
        first_y_d     = vpos;
        first_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (write_enable && (address == CX_MASK_LO)) begin
      mask_d[7:0] = data_in;
    end
    if (write_enable && (address == CX_MASK_HI)) begin
      mask_d[14:8] = data_in[6:0];
    end
  end

  always_comb begin
    rd_dat = 8'h00;
    case (address)
      CX_LO:      rd_dat = latch_q[7:0];
      CX_HI:      rd_dat = pair_hi_byte(latch_q);
      CX_MASK_LO: rd_dat = mask_q[7:0];
      CX_MASK_HI: rd_dat = pair_hi_byte(mask_q);
      CX_FX_LO:   rd_dat = first_x_q[7:0];
      CX_FX_HI:   rd_dat = {first_valid_q, 5'b0, first_x_q[9:8]};
      CX_FY_LO:   rd_dat = first_y_q[7:0];
      CX_FY_HI:   rd_dat = {6'b0, first_y_q[9:8]};
      default:    rd_dat = 8'h00;
    endcase
  end

  always_comb begin
    data_out_d = data_out_q;
    if (enable && !write_enable) begin
      data_out_d = rd_dat;
    end
  end

  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      latch_q       <= '0;
      mask_q        <= '0;
      first_x_q     <= '0;
      first_y_q     <= '0;
      first_valid_q <= 1'b0;
      data_out_q    <= 8'h00;
    end else begin
      latch_q       <= latch_d;
      mask_q        <= mask_d;
      first_x_q     <= first_x_d;
      first_y_q     <= first_y_d;
      first_valid_q <= first_valid_d;
      data_out_q    <= data_out_d;
    end
  end

  assign data_out      = data_out_q;
  assign collision_any = |(latch_q & ~mask_q);

endmodule

// File: tb/tb_collision_detect.sv
// Directed bench for collision_detect with hand-computed register and pair values.
module tb_collision_detect;
  import collision_detect_pkg::*;

  logic       raw_clk = 1'b0;
  logic       reset;
  logic       enable, write_enable;
  logic [3:0] address;
  logic [7:0] data_in, data_out;
  logic       in_image;
  logic [9:0] hpos, vpos;
  logic       p0, p1, m0, m1, bl, pf;
  logic       collision_any;

  logic [5:0]           tm_obj;
  logic [NUM_PAIRS-1:0] tm_hit;

  int n_tests = 0;
  int n_fail  = 0;

  collision_detect #(.POS_WIDTH(10)) dut (
    .raw_clk       (raw_clk),
    .reset         (reset),
    .enable        (enable),
    .write_enable  (write_enable),
    .address       (address),
    .data_in       (data_in),
    .data_out      (data_out),
    .in_image      (in_image),
    .hpos          (hpos),
    .vpos          (vpos),
    .p0            (p0),
    .p1            (p1),
    .m0            (m0),
    .m1            (m1),
    .bl            (bl),
    .pf            (pf),
    .collision_any (collision_any)
  );

  collision_pair_matrix u_tm (
    .p0  (tm_obj[5]),
    .p1  (tm_obj[4]),
    .m0  (tm_obj[3]),
    .m1  (tm_obj[2]),
    .bl  (tm_obj[1]),
    .pf  (tm_obj[0]),
    .hit (tm_hit)
  );

  always #5 raw_clk = ~raw_clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge raw_clk);
    @(negedge raw_clk);
  endtask

  task automatic set_obj(input logic [5:0] o);
    {p0, p1, m0, m1, bl, pf} = o;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
    enable = 1'b1; write_enable = 1'b0; address = a;
    cycle();
    enable = 1'b0;
    check(tag, {8'h00, data_out}, {8'h00, exp});
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    write_enable = 1'b1; address = a; data_in = d;
    cycle();
    write_enable = 1'b0;
  endtask

  // One pixel: objects {p0,p1,m0,m1,bl,pf} at (h,v), then objects off
  task automatic pix(input logic [5:0] o, input logic img, input logic [9:0] h, input logic [9:0] v);
    set_obj(o); in_image = img; hpos = h; vpos = v;
    cycle();
    set_obj(6'b0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; write_enable = 1'b0; address = 4'h0; data_in = 8'h00;
    in_image = 1'b0; hpos = '0; vpos = '0; tm_obj = 6'b0;
    set_obj(6'b0);

    // Pair matrix bit order
    tm_obj = 6'b110000; #1 check("mx_p0p1", {1'b0, tm_hit}, 16'h2000);
    tm_obj = 6'b011000; #1 check("mx_m0p1", {1'b0, tm_hit}, 16'h0001);
    tm_obj = 6'b000111; #1 check("mx_m1blpf", {1'b0, tm_hit}, 16'h1C00);
    tm_obj = 6'b101010; #1 check("mx_p0m0bl", {1'b0, tm_hit}, 16'h0222);
    tm_obj = 6'b100000; #1 check("mx_single", {1'b0, tm_hit}, 16'h0000);
    tm_obj = 6'b111111; #1 check("mx_all", {1'b0, tm_hit}, 16'h7FFF);

    @(negedge raw_clk);
    @(negedge raw_clk);
    check("rst_dout", {8'h00, data_out}, 16'h0000);
    check("rst_any", {15'h0, collision_any}, 16'h0000);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) rd(4'(a), 8'h00, "rst_read");
    rd(4'h9, 8'h00, "rd_unmapped");
    check("rst_any2", {15'h0, collision_any}, 16'h0000);

    // P0PF at (100,50)
    pix(6'b100001, 1'b1, 10'd100, 10'd50);
    check("p0pf_any", {15'h0, collision_any}, 16'h0001);
    rd(CX_LO, 8'h10, "p0pf_lo");
    rd(CX_HI, 8'h00, "p0pf_hi");
    rd(CX_FX_LO, 8'h64, "p0pf_fx_lo");
    rd(CX_FX_HI, 8'h80, "p0pf_fx_hi");
    rd(CX_FY_LO, 8'h32, "p0pf_fy_lo");
    rd(CX_FY_HI, 8'h00, "p0pf_fy_hi");
    rd(CX_LO, 8'h10, "read_no_clear");

    // Clear, then same overlap outside the image
    wr(CX_CLEAR, 8'h00);
    check("clr_any", {15'h0, collision_any}, 16'h0000);
    rd(CX_FX_LO, 8'h64, "clr_fx_hold");
    pix(6'b100001, 1'b0, 10'd100, 10'd50);
    check("blank_any", {15'h0, collision_any}, 16'h0000);
    rd(CX_LO, 8'h00, "blank_lo");
    rd(CX_HI, 8'h00, "blank_hi");
    rd(CX_FX_HI, 8'h00, "blank_fx_hi");

    // Masked P0PF still latches but does not capture
    wr(CX_MASK_LO, 8'h10);
    rd(CX_MASK_LO, 8'h10, "mask_lo");
    pix(6'b100001, 1'b1, 10'd200, 10'd60);
    check("masked_any", {15'h0, collision_any}, 16'h0000);
    pix(6'b001100, 1'b1, 10'd300, 10'd70);
    check("m0m1_any", {15'h0, collision_any}, 16'h0001);
    rd(CX_LO, 8'h10, "m0m1_lo");
    rd(CX_HI, 8'h40, "m0m1_hi");
    rd(CX_FX_LO, 8'h2C, "m0m1_fx_lo");
    rd(CX_FX_HI, 8'h81, "m0m1_fx_hi");
    rd(CX_FY_LO, 8'h46, "m0m1_fy_lo");
    rd(CX_FY_HI, 8'h00, "m0m1_fy_hi");

    // Upper mask byte drops bit 7 of the write
    wr(CX_MASK_HI, 8'hFF);
    rd(CX_MASK_HI, 8'h7F, "mask_hi");
    check("all_masked_any", {15'h0, collision_any}, 16'h0000);
    wr(CX_MASK_LO, 8'h00);
    wr(CX_MASK_HI, 8'h00);
    check("unmasked_any", {15'h0, collision_any}, 16'h0001);

    // Clear on the same edge as BLPF: hit is discarded
    write_enable = 1'b1; address = CX_CLEAR; data_in = 8'h00;
    set_obj(6'b000011); in_image = 1'b1; hpos = 10'h3FF; vpos = 10'h3FF;
    cycle();
    write_enable = 1'b0;
    check("clr_hit_any", {15'h0, collision_any}, 16'h0000);
    hpos = 10'h205; vpos = 10'h301;
    cycle();
    set_obj(6'b000000);
    check("blpf_any", {15'h0, collision_any}, 16'h0001);
    rd(CX_LO, 8'h00, "blpf_lo");
    rd(CX_HI, 8'h10, "blpf_hi");
    rd(CX_FX_HI, 8'h82, "blpf_fx_hi");
    rd(CX_FY_LO, 8'h01, "blpf_fy_lo");
    rd(CX_FY_HI, 8'h03, "blpf_fy_hi");
    rd(CX_FX_LO, 8'h05, "blpf_fx_lo");
    address = CX_FX_HI;
    cycle();
    check("dout_hold", {8'h00, data_out}, 16'h0005);

    // Full latch and mask, then asynchronous reset between edges
    wr(CX_MASK_LO, 8'hFF);
    wr(CX_MASK_HI, 8'hFF);
    pix(6'b111111, 1'b1, 10'd10, 10'd20);
    check("full_any", {15'h0, collision_any}, 16'h0000);
    rd(CX_LO, 8'hFF, "full_lo");
    rd(CX_HI, 8'h7F, "full_hi");
    #2 reset = 1'b1;
    #1 check("async_dout", {8'h00, data_out}, 16'h0000);
    #1 reset = 1'b0;
    @(negedge raw_clk);
    rd(CX_LO, 8'h00, "post_rst_lo");
    rd(CX_HI, 8'h00, "post_rst_hi");
    rd(CX_MASK_LO, 8'h00, "post_rst_mask_lo");
    rd(CX_MASK_HI, 8'h00, "post_rst_mask_hi");
    rd(CX_FX_HI, 8'h00, "post_rst_fx_hi");
    rd(CX_FY_LO, 8'h00, "post_rst_fy_lo");
    pix(6'b010010, 1'b1, 10'd40, 10'd41);
    check("p1bl_any", {15'h0, collision_any}, 16'h0001);
    rd(CX_LO, 8'h80, "p1bl_lo");
    rd(CX_FX_LO, 8'h28, "p1bl_fx_lo");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
